// File: rtl/cpu_pkg.sv
// Shared register-file constants and the writeback request record used by
// the write-port arbiter.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_NUM    = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [REG_NUM-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    return REG_NUM'(1) << a;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from r_ptr,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int               j_int;
    logic [IDX_W-1:0] j;
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j_int = int'(r_ptr) + i;
      if (j_int >= NUM_REQ) j_int = j_int - NUM_REQ;
      j = IDX_W'(j_int);
      if (!w_found && i_enable && i_req[j]) begin
        w_found     = 1'b1;
        o_grant[j]  = 1'b1;
        o_grant_idx = j;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      if (o_grant_idx == IDX_W'(NUM_REQ - 1)) r_ptr <= '0;
      else                                    r_ptr <= o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback sources:
// round-robin grant, registered write stage, pending mask and commit counter.
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*REG_DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_hold,
  output logic                          o_regWe,
  output logic [REG_ADDR_W-1:0]         o_WRA,
  output logic [REG_DATA_W-1:0]         o_WRD,
  output logic [REG_NUM-1:0]            o_pending,
  output logic [CNT_W-1:0]              o_commit_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wb_req_t              w_req [NUM_REQ];
  wb_req_t              w_sel;
  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_handshake;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_wra;
  logic [REG_DATA_W-1:0] r_wrd;
  logic [CNT_W-1:0]      r_cnt;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_req[k] = '{addr: i_req_addr[k*REG_ADDR_W +: REG_ADDR_W],
                        data: i_req_data[k*REG_DATA_W +: REG_DATA_W]};
  end

  // Grants are gated by reset so nothing is acknowledged while rstn is low.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .i_req       (i_req_valid),
    .i_enable    (~i_hold & rstn),
    .i_advance   (w_handshake),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_handshake = |w_grant;
  assign w_sel       = w_req[w_grant_idx];
  assign o_req_ready = w_grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we  <= 1'b0;
      r_wra <= '0;
      r_wrd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_handshake) begin
        r_we  <= (w_sel.addr != REG_ZERO);
        r_wra <= w_sel.addr;
        r_wrd <= w_sel.data;
      end else begin
        r_we  <= 1'b0;
      end
      if (r_we) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_regWe      = r_we;
  assign o_WRA        = r_wra;
  assign o_WRD        = r_wrd;
  assign o_pending    = r_we ? addr_onehot(r_wra) : '0;
  assign o_commit_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// that captures o_WRD at the edge after o_regWe is presented.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        hold;
  logic [2:0]  req_ready;
  logic        regwe;
  logic [4:0]  wra;
  logic [31:0] wrd;
  logic [31:0] pending;
  logic [15:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_rf [32];

  regfile_write_arbiter #(.NUM_REQ(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .i_hold       (hold),
    .o_regWe      (regwe),
    .o_WRA        (wra),
    .o_WRD        (wrd),
    .o_pending    (pending),
    .o_commit_cnt (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (regwe) model_rf[wra] <= wrd;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rstn      = 1'b0;
    req_valid = '0;
    hold      = 1'b0;
    #2;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; hold = 1'b0;
    #3;
    n_tests++; if (regwe !== 1'b0)   begin n_fail++; $display("FAIL reset_we: got %b want 0", regwe); end
    n_tests++; if (wra !== 5'd0)     begin n_fail++; $display("FAIL reset_wra: got %h want 0", wra); end
    n_tests++; if (wrd !== 32'd0)    begin n_fail++; $display("FAIL reset_wrd: got %h want 0", wrd); end
    n_tests++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_tests++; if (cnt !== 16'd0)    begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single;
    apply_reset();
    req_valid = 3'b001; req_addr[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (regwe !== 1'b1)        begin n_fail++; $display("FAIL single_we: got %b want 1", regwe); end
    n_tests++; if (wra !== 5'd5)          begin n_fail++; $display("FAIL single_wra: got %0d want 5", wra); end
    n_tests++; if (wrd !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL single_wrd: got %h want deadbeef", wrd); end
    n_tests++; if (pending !== 32'h20)    begin n_fail++; $display("FAIL single_pending: got %h want 20", pending); end
    n_tests++; if (cnt !== 16'd0)         begin n_fail++; $display("FAIL single_cnt0: got %0d want 0", cnt); end
    tick();
    n_tests++; if (cnt !== 16'd1)         begin n_fail++; $display("FAIL single_cnt1: got %0d want 1", cnt); end
    n_tests++; if (regwe !== 1'b0)        begin n_fail++; $display("FAIL single_idle: got %b want 0", regwe); end
    n_tests++; if (model_rf[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf5: got %h want deadbeef", model_rf[5]); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0] exp_addr  [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    apply_reset();
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tests++; if (req_ready !== exp_ready[i]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp_ready[i]); end
      tick();
      n_tests++; if (regwe !== 1'b1 || wra !== exp_addr[i]) begin n_fail++; $display("FAIL rr_write[%0d]: got we=%b wra=%0d want we=1 wra=%0d", i, regwe, wra, exp_addr[i]); end
    end
    req_valid = '0;
    n_tests++; if (wrd !== 32'hC0C0_0003) begin n_fail++; $display("FAIL rr_wrd: got %h want c0c00003", wrd); end
    tick();
    n_tests++; if (cnt !== 16'd6) begin n_fail++; $display("FAIL rr_cnt: got %0d want 6", cnt); end
    n_tests++; if (regwe !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", regwe); end
  endtask

  task automatic test_r0;
    apply_reset();
    req_addr = {5'd4, 5'd0, 5'd6};
    req_data = {32'h3, 32'h1234_5678, 32'h1};
    req_valid = 3'b010;
    #1;
    n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL r0_ready: got %b want 010", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (regwe !== 1'b0)     begin n_fail++; $display("FAIL r0_we: got %b want 0", regwe); end
    n_tests++; if (pending !== 32'd0)  begin n_fail++; $display("FAIL r0_pending: got %h want 0", pending); end
    req_valid = 3'b111;
    #1;
    n_tests++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL r0_ptr: got %b want 100", req_ready); end
    req_valid = '0;
    tick();
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL r0_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_hold;
    apply_reset();
    req_addr = {5'd9, 5'd0, 5'd10};
    req_data = {32'h99, 32'h0, 32'h1010};
    hold = 1'b1;
    req_valid = 3'b100;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b want 000", i, req_ready); end
      tick();
      n_tests++; if (regwe !== 1'b0) begin n_fail++; $display("FAIL hold_we[%0d]: got %b want 0", i, regwe); end
    end
    hold = 1'b0;
    #1;
    n_tests++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL hold_release: got %b want 100", req_ready); end
    tick();
    n_tests++; if (regwe !== 1'b1 || wra !== 5'd9) begin n_fail++; $display("FAIL hold_write: got we=%b wra=%0d want we=1 wra=9", regwe, wra); end
    req_valid = 3'b001;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL hold_wrap: got %b want 001", req_ready); end
    tick();
    hold = 1'b1;
    req_valid = 3'b010;
    #1;
    n_tests++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL hold_mid_ready: got %b want 000", req_ready); end
    n_tests++; if (regwe !== 1'b1 || wra !== 5'd10) begin n_fail++; $display("FAIL hold_inflight: got we=%b wra=%0d want we=1 wra=10", regwe, wra); end
    tick();
    n_tests++; if (regwe !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got %b want 0", regwe); end
    req_valid = '0;
    hold = 1'b0;
  endtask

  task automatic test_same_addr;
    apply_reset();
    req_addr = {5'd0, 5'd7, 5'd7};
    req_data = {32'h0, 32'd2, 32'd1};
    req_valid = 3'b011;
    #1;
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL same_first: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b010;
    #1;
    n_tests++; if (regwe !== 1'b1 || wrd !== 32'd1) begin n_fail++; $display("FAIL same_w1: got we=%b wrd=%h want we=1 wrd=1", regwe, wrd); end
    n_tests++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL same_second: got %b want 010", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (regwe !== 1'b1 || wra !== 5'd7 || wrd !== 32'd2) begin n_fail++; $display("FAIL same_w2: got we=%b wra=%0d wrd=%h want 1/7/2", regwe, wra, wrd); end
    tick();
    n_tests++; if (model_rf[7] !== 32'd2) begin n_fail++; $display("FAIL same_rf7: got %h want 2", model_rf[7]); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    req_addr = {5'd13, 5'd12, 5'd11};
    req_data = {32'h33, 32'h22, 32'h11};
    req_valid = 3'b111;
    tick();
    tick();
    n_tests++; if (regwe !== 1'b1 || wra !== 5'd12) begin n_fail++; $display("FAIL ar_pre: got we=%b wra=%0d want we=1 wra=12", regwe, wra); end
    #2;
    rstn = 1'b0;
    #1;
    n_tests++; if (regwe !== 1'b0 || wra !== 5'd0 || wrd !== 32'd0) begin n_fail++; $display("FAIL ar_clear: got we=%b wra=%0d wrd=%h want 0/0/0", regwe, wra, wrd); end
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", cnt); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_tests++; if (regwe !== 1'b0) begin n_fail++; $display("FAIL ar_noreplay: got %b want 0", regwe); end
    n_tests++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL ar_restart: got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (regwe !== 1'b1 || wra !== 5'd11) begin n_fail++; $display("FAIL ar_first: got we=%b wra=%0d want we=1 wra=11", regwe, wra); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_r0();
    test_hold();
    test_same_addr();
    test_async_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (regWe / WRA / WRD) between NUM_REQ writeback sources, e.g. ALU result, load data and link address.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered output stage drives the register file's write port directly.
- Also provides a pending-write mask for hazard checks and a committed-write counter for debug.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8).
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rstn  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester write request.
- i_req_addr  input  NUM_REQ*5  per-requester destination register; requester k uses bits [5k+4:5k].
- i_req_data  input  NUM_REQ*32  per-requester write data; requester k uses bits [32k+31:32k].
- o_req_ready  output  NUM_REQ  grant; a handshake occurs on a rising edge where valid[k]&ready[k].
- i_hold  input  1  suspends arbitration; no grants while high.
- o_regWe  output  1  write enable to the register file.
- o_WRA  output  5  write address to the register file.
- o_WRD  output  32  write data to the register file.
- o_pending  output  32  one-hot of o_WRA when o_regWe=1, else all zero.
- o_commit_cnt  output  CNT_W  count of writes presented with o_regWe=1.

Behaviour:
- Reset (rstn low, asynchronous): o_regWe=0, o_WRA=0, o_WRD=0, rr_ptr=0, o_commit_cnt=0. o_pending=0 as a consequence. o_req_ready is combinational and therefore 0.
- Reset release mid-stream: requests held across reset are arbitrated from rr_ptr=0 on the first edge after rstn rises. No write asserted before reset is replayed.
- Arbitration (combinational):
  - If i_hold=1 or no valid, o_req_ready=0.
  - Otherwise exactly one bit is set: the first valid index found searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - o_req_ready never depends on o_req_ready, and never has more than one bit high.
- Handshake at edge for requester g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - o_WRA <= addr[g], o_WRD <= data[g].
  - o_regWe <= (addr[g] != 0).
- Address 0: accepted and acknowledged normally. It produces no write, no pending bit and no count.
- No handshake at an edge: o_regWe <= 0, rr_ptr unchanged. o_WRA/o_WRD hold their last value (don't care while o_regWe=0).
- Latency:
  - Handshake at edge k gives o_regWe=1 during cycle k..k+1.
  - The register file captures the write at edge k+1; a read after edge k+1 returns the new value.
  - Sustained throughput is one write per cycle.
- o_commit_cnt increments by 1 at each edge where o_regWe=1, and wraps from 2^CNT_W-1 to 0.
- i_hold:
  - Rising mid-stream: blocks the next grant only. An already-registered write still completes (o_regWe stays 1 for its cycle).
  - Held for N cycles: o_regWe=0 for those cycles after the in-flight write drains. Requests stay pending.
- Requester contract: a requester keeps valid, addr and data stable until its handshake. Violations are not detected.
- Same address from two requesters: writes are serialised in grant order; the later grant wins.
- Single-requester NUM_REQ=1: degenerates to a registered pass-through with ready=~i_hold.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32, REG_ZERO=5'd0.
  - A typedef wb_req_t {addr, data}.
- One sub-module: rr_arbiter (NUM_REQ-wide).
  - Inputs: req, enable, advance.
  - Outputs: one-hot grant, grant index.
  - Owns rr_ptr with its own async active-low reset.
- Top level keeps the output register, pending decode and counter.

Test Plan:
- Single request: valid[0]=1, addr=5, data=32'hDEADBEEF → ready[0]=1 that cycle; next cycle o_regWe=1, o_WRA=5, o_WRD=DEADBEEF, o_pending=32'h20; cnt 0→1 after one more edge.
- All three valid continuously with rr_ptr=0 → grant order 0,1,2,0,1,2 over six cycles; o_regWe=1 every cycle from the second; cnt=6 after seven edges.
- Write to r0: valid[1]=1, addr=0 → handshake occurs; o_regWe stays 0, o_pending=0, cnt unchanged; rr_ptr advances to 2.
- i_hold=1 for 4 cycles with valid[2]=1 → ready=0 throughout, o_regWe=0; first grant to req 2 on the cycle hold drops, o_regWe=1 one cycle later.
- Same address: req0 addr=7 data=1 and req1 addr=7 data=2 both valid → two consecutive writes to r7; regfile r7 reads 2 afterwards.
- Async reset mid-burst: drop rstn between edges while o_regWe=1 → o_regWe, o_WRA, o_WRD, cnt go 0 immediately without a clock edge; after release, grants restart at requester 0.
